// File: rtl/uart_pkg.sv
// Shared types for the UART transmit/receive arbitration blocks.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_t;

  localparam int unsigned FRAME_CNT_W = 16;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: the first set request at or above ptr, wrapping.
module uart_rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any_req
);

  logic [IDX_W-1:0] cand;

  // Scan candidates in priority order ptr, ptr+1, ... and keep the first hit.
  always_comb begin
    grant   = '0;
    idx     = '0;
    any_req = 1'b0;
    cand    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((32'(ptr) + k) % NUM_REQ);
      if (!any_req && req[cand]) begin
        any_req     = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ requesters.
// One byte is latched per grant and the grant is held until the frame completes.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                          cpu_clk,
  input  logic                          cpu_rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  input  logic                          out_ready,
  input  logic                          tx_done,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy,
  output logic [FRAME_CNT_W-1:0]        frame_cnt
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  arb_state_t             state_q, state_d;
  logic [IdxW-1:0]        ptr_q, ptr_d;
  logic [IdxW-1:0]        grant_id_q, grant_id_d;
  logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic                   tx_done_prev_q;
  logic                   tx_done_pulse;

  logic [NUM_REQ-1:0]     pick_grant;
  logic [IdxW-1:0]        pick_idx;
  logic                   pick_any;
  logic [DATA_WIDTH-1:0]  req_bytes [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_bytes[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IdxW)
  ) u_pick (
    .req     (req_valid),
    .ptr     (ptr_q),
    .grant   (pick_grant),
    .idx     (pick_idx),
    .any_req (pick_any)
  );

  // tx_done is a level; only a fresh rising edge ends a frame.
  assign tx_done_pulse = tx_done & ~tx_done_prev_q;

  // State register, hold register, pointer, counter and edge-detector flop.
  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst_n) begin
      state_q        <= IDLE;
      ptr_q          <= '0;
      grant_id_q     <= '0;
      out_data_q     <= '0;
      frame_cnt_q    <= '0;
      tx_done_prev_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      grant_id_q     <= grant_id_d;
      out_data_q     <= out_data_d;
      frame_cnt_q    <= frame_cnt_d;
      tx_done_prev_q <= tx_done;
    end
  end

  // Next-state and output decode; pulses outside WAIT_DONE are stale and ignored.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_id_d  = grant_id_q;
    out_data_d  = out_data_q;
    frame_cnt_d = frame_cnt_q;
    req_ready   = '0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_rst_n) begin
          req_ready = pick_grant;
          if (pick_any) begin
            out_data_d = req_bytes[pick_idx];
            grant_id_d = pick_idx;
            state_d    = SEND;
          end
        end
      end
      SEND: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        busy = 1'b1;
        if (tx_done_pulse) begin
          // The just-served requester drops to lowest priority.
          ptr_d       = (grant_id_q == IdxW'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
          frame_cnt_d = frame_cnt_q + 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_data  = out_data_q;
  assign grant_id  = grant_id_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a transaction-level reference model.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;

  logic          cpu_clk = 1'b0;
  logic          cpu_rst_n;
  logic [NR-1:0] req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0] req_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic          tx_done;
  logic [1:0]    grant_id;
  logic          busy;
  logic [15:0]   frame_cnt;

  uart_tx_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW)
  ) dut (
    .cpu_clk   (cpu_clk),
    .cpu_rst_n (cpu_rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .tx_done   (tx_done),
    .grant_id  (grant_id),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  always #5 cpu_clk = ~cpu_clk;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  // Reference model: a byte is either absent, offered, or handed over and awaiting frame end.
  bit          m_held   = 1'b0;
  bit          m_taken  = 1'b0;
  int          m_ptr    = 0;
  int          m_gid    = 0;
  logic [7:0]  m_byte   = '0;
  logic [15:0] m_frames = '0;
  logic        m_prev   = 1'b0;

  function automatic int rr_winner(logic [NR-1:0] v, int p);
    for (int k = 0; k < NR; k++) begin
      if (v[(p + k) % NR]) return (p + k) % NR;
    end
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h, required %0h", name, act, exp);
  endtask

  task automatic model_update();
    int   w;
    logic pulse;
    if (!cpu_rst_n) begin
      m_held = 1'b0; m_taken = 1'b0; m_ptr = 0; m_gid = 0;
      m_byte = '0; m_frames = '0; m_prev = 1'b0;
    end else begin
      pulse  = tx_done && !m_prev;
      m_prev = tx_done;
      if (!m_held) begin
        w = rr_winner(req_valid, m_ptr);
        if (w >= 0) begin
          m_held  = 1'b1;
          m_taken = 1'b0;
          m_byte  = req_data[w*DW +: DW];
          m_gid   = w;
        end
      end else if (!m_taken) begin
        if (out_ready) m_taken = 1'b1;
      end else if (pulse) begin
        m_held   = 1'b0;
        m_taken  = 1'b0;
        m_ptr    = (m_gid + 1) % NR;
        m_frames = m_frames + 16'd1;
      end
    end
  endtask

  task automatic compare_all();
    int            w;
    logic [NR-1:0] exp_ready;
    exp_ready = '0;
    if (cpu_rst_n && !m_held) begin
      w = rr_winner(req_valid, m_ptr);
      if (w >= 0) exp_ready[w] = 1'b1;
    end
    check("cyc req_ready", 32'(req_ready), 32'(exp_ready));
    check("cyc out_valid", 32'(out_valid), 32'(m_held && !m_taken));
    check("cyc out_data",  32'(out_data),  32'(m_byte));
    check("cyc grant_id",  32'(grant_id),  32'(m_gid));
    check("cyc busy",      32'(busy),      32'(m_held));
    check("cyc frame_cnt", 32'(frame_cnt), 32'(m_frames));
  endtask

  // Compare at the falling edge, then advance the model on the rising edge.
  task automatic step();
    @(negedge cpu_clk);
    if (chk_en) compare_all();
    @(posedge cpu_clk);
    model_update();
    #1;
  endtask

  initial begin
    int         exp_g [5] = '{0, 1, 2, 3, 0};
    logic [7:0] exp_d [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};

    cpu_rst_n = 1'b0;
    req_valid = 4'b0011;
    req_data  = '0;
    out_ready = 1'b0;
    tx_done   = 1'b0;
    step();
    chk_en = 1'b1;
    step();
    check("rst req_ready", 32'(req_ready), 32'h0);
    check("rst out_valid", 32'(out_valid), 32'h0);
    check("rst busy",      32'(busy),      32'h0);
    check("rst frame_cnt", 32'(frame_cnt), 32'h0);
    check("rst grant_id",  32'(grant_id),  32'h0);
    check("rst out_data",  32'(out_data),  32'h0);

    // Single request.
    cpu_rst_n = 1'b1;
    req_valid = '0;
    step();
    req_valid = 4'b0100;
    req_data  = 32'h11A52233;
    #1 check("single req_ready", 32'(req_ready), 32'h4);
    step();
    req_valid = '0;
    #1;
    check("single out_valid", 32'(out_valid), 32'h1);
    check("single out_data",  32'(out_data),  32'hA5);
    check("single grant_id",  32'(grant_id),  32'h2);
    check("single busy",      32'(busy),      32'h1);
    check("single ready_off", 32'(req_ready), 32'h0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("single wait valid", 32'(out_valid), 32'h0);
    check("single wait busy",  32'(busy),      32'h1);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    check("single frame_cnt", 32'(frame_cnt), 32'h1);
    check("single idle busy", 32'(busy),      32'h0);
    check("single gid hold",  32'(grant_id),  32'h2);
    step();

    // Round-robin rotation from a fresh reset.
    cpu_rst_n = 1'b0;
    step();
    cpu_rst_n = 1'b1;
    req_valid = 4'b1111;
    req_data  = 32'h13121110;
    out_ready = 1'b1;
    for (int f = 0; f < 5; f++) begin
      step();
      check("rr grant_id", 32'(grant_id), 32'(exp_g[f]));
      check("rr out_data", 32'(out_data), 32'(exp_d[f]));
      step();
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
    end
    req_valid = '0;
    out_ready = 1'b0;
    #1 check("rr frame_cnt", 32'(frame_cnt), 32'h5);

    // Back-pressure with changing source data.
    req_valid = 4'b0010;
    req_data[15:8] = 8'h3C;
    step();
    for (int i = 0; i < 10; i++) begin
      req_data[15:8] = 8'(i * 17 + 1);
      #1;
      check("bp out_valid", 32'(out_valid), 32'h1);
      check("bp out_data",  32'(out_data),  32'h3C);
      check("bp req_ready", 32'(req_ready), 32'h0);
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    req_valid = '0;
    tx_done   = 1'b1;
    step();
    tx_done = 1'b0;
    #1 check("bp frame_cnt", 32'(frame_cnt), 32'h6);

    // Stale and level tx_done; pointer is 2, so the lone request at 0 wins after wrap.
    req_valid = 4'b0001;
    req_data[7:0] = 8'h77;
    step();
    check("lvl grant_id", 32'(grant_id), 32'h0);
    req_valid = '0;
    tx_done   = 1'b1;
    step();
    check("lvl send valid", 32'(out_valid), 32'h1);
    check("lvl send cnt",   32'(frame_cnt), 32'h6);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    repeat (3) step();
    check("lvl wait busy", 32'(busy),      32'h1);
    check("lvl wait cnt",  32'(frame_cnt), 32'h6);
    tx_done = 1'b0;
    step();
    check("lvl low busy", 32'(busy), 32'h1);
    tx_done = 1'b1;
    step();
    check("lvl exit busy", 32'(busy),      32'h0);
    check("lvl exit cnt",  32'(frame_cnt), 32'h7);
    tx_done = 1'b0;
    step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    step();
    check("idle stale cnt", 32'(frame_cnt), 32'h7);

    // Reset while waiting for frame end.
    req_valid = 4'b0100;
    req_data[23:16] = 8'h99;
    out_ready = 1'b1;
    step();
    req_valid = '0;
    step();
    check("rstw busy before", 32'(busy), 32'h1);
    cpu_rst_n = 1'b0;
    req_valid = 4'b0110;
    #1 check("rstw req_ready", 32'(req_ready), 32'h0);
    step();
    check("rstw out_valid", 32'(out_valid), 32'h0);
    check("rstw busy",      32'(busy),      32'h0);
    check("rstw frame_cnt", 32'(frame_cnt), 32'h0);
    cpu_rst_n = 1'b1;
    #1 check("rstw next ready", 32'(req_ready), 32'h2);
    step();
    check("rstw next gid", 32'(grant_id), 32'h1);
    req_valid = '0;
    step();
    tx_done = 1'b1;
    step();
    tx_done   = 1'b0;
    out_ready = 1'b0;
    check("rstw frame_cnt after", 32'(frame_cnt), 32'h1);

    // Counter wrap.
    force dut.frame_cnt_q = 16'hFFFF;
    m_frames = 16'hFFFF;
    step();
    release dut.frame_cnt_q;
    #1 check("wrap preload", 32'(frame_cnt), 32'hFFFF);
    req_valid = 4'b1000;
    req_data[31:24] = 8'hE1;
    out_ready = 1'b1;
    step();
    req_valid = '0;
    check("wrap out_data", 32'(out_data), 32'hE1);
    step();
    tx_done = 1'b1;
    step();
    tx_done   = 1'b0;
    out_ready = 1'b0;
    check("wrap frame_cnt", 32'(frame_cnt), 32'h0);
    check("wrap grant_id",  32'(grant_id),  32'h3);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
